issue_queue: RTL and testbench

- Parametrised out-of-order issue queue; successor to the single-port execution buffer.
- Sits between rename/dispatch and the ALU/execute stage.
- Holds up to DEPTH renamed ops, wakes source operands from W broadcast ports and issues the oldest ready op through a valid/ready handshake.
- Supports full-pipeline flush and reports occupancy.

---
 rtl/issue_queue_pkg.sv | 30 +++
 rtl/iq_age_select.sv | 65 ++++++
 rtl/issue_queue.sv | 223 ++++++++++++++++++++++
 tb/tb_issue_queue.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared types and default sizes for the issue queue and its age-select unit.
package issue_queue_pkg;

    // Register-file sizes that the tag and special-register widths are derived from.
    localparam int NUM_D_REG       = 64;
    localparam int NUM_S_REG       = 8;
    // Default number of result-broadcast ports feeding the queue.
    localparam int NUM_WAKEUP_DFLT = 2;

    // ALU operation carried through the queue untouched.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NAND = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_MOV  = 4'd11,
        ALU_LUI  = 4'd12,
        ALU_MFS  = 4'd13,
        ALU_MTS  = 4'd14,
        ALU_NOP  = 4'd15
    } AluOp;

endpackage

// File: rtl/iq_age_select.sv
// Age matrix plus oldest-ready selection for the issue queue.
// age_reg[i][j] = 1 means entry i was allocated before entry j.
module iq_age_select #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [DEPTH-1:0]         ready,
    input  logic [DEPTH-1:0]         valid,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx,
    output logic [DEPTH-1:0]         grant,
    output logic [$clog2(DEPTH)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] age_reg [DEPTH];
    logic [DEPTH-1:0] older_ready;

    // Allocation makes the new entry the youngest: its own row is cleared and
    // every surviving entry gains a bit saying it is older than the new one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_reg[i] <= '0;
            end
        end else if (alloc_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(i) == alloc_idx) begin
                        age_reg[i][j] <= 1'b0;
                    end else if ((IDX_W'(j) == alloc_idx) && valid[i]) begin
                        age_reg[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // An entry wins when it is ready and no other ready entry is older than it.
    // Rows of free entries may be stale, but free entries are never ready.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
        logic [DEPTH-1:0] older_col;
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
            if (gj == gi) begin : g_diag
                assign older_col[gj] = 1'b0;
            end else begin : g_off
                assign older_col[gj] = age_reg[gj][gi];
            end
        end
        assign older_ready[gi] = |(older_col & ready);
        assign grant[gi]       = ready[gi] & ~older_ready[gi];
    end

    // One-hot grant to binary index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed ops, wakes their sources from the
// result broadcast ports and presents the oldest ready op to execute.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int NUM_WAKEUP = NUM_WAKEUP_DFLT,
    parameter int TAG_W      = $clog2(NUM_D_REG),
    parameter int ROB_W      = 4,
    parameter int RS_W       = $clog2(NUM_S_REG)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [ROB_W-1:0]            disp_rob,
    input  AluOp                        disp_alu_op,
    input  logic [5:0]                  disp_immdt,
    input  logic                        disp_use_ra,
    input  logic                        disp_use_rt,
    input  logic [TAG_W-1:0]            disp_ra_tag,
    input  logic [TAG_W-1:0]            disp_rt_tag,
    input  logic                        disp_ra_rdy,
    input  logic                        disp_rt_rdy,
    input  logic                        disp_use_rw,
    input  logic [TAG_W-1:0]            disp_rw_tag,
    input  logic [15:0]                 disp_rv_addr,
    input  logic [RS_W-1:0]             disp_rs_addr,
    input  logic [NUM_WAKEUP-1:0]       wk_valid,
    input  logic [NUM_WAKEUP*TAG_W-1:0] wk_tag,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [ROB_W-1:0]            iss_rob,
    output AluOp                        iss_alu_op,
    output logic [5:0]                  iss_immdt,
    output logic [TAG_W-1:0]            iss_ra_tag,
    output logic                        iss_use_rt,
    output logic [TAG_W-1:0]            iss_rt_tag,
    output logic                        iss_use_rw,
    output logic [TAG_W-1:0]            iss_rw_tag,
    output logic [15:0]                 iss_rv_addr,
    output logic [RS_W-1:0]             iss_rs_addr,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Payload of one queued op; ready bits live in separate vectors since they
    // are updated every cycle by wakeup while the payload is write-once.
    typedef struct packed {
        logic [ROB_W-1:0] rob;
        AluOp             alu_op;
        logic [5:0]       immdt;
        logic             use_ra;
        logic [TAG_W-1:0] ra_tag;
        logic             use_rt;
        logic [TAG_W-1:0] rt_tag;
        logic             use_rw;
        logic [TAG_W-1:0] rw_tag;
        logic [15:0]      rv_addr;
        logic [RS_W-1:0]  rs_addr;
    } entry_t;

    entry_t           entry_reg [DEPTH];
    entry_t           disp_entry;
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] ra_rdy_reg, ra_rdy_next;
    logic [DEPTH-1:0] rt_rdy_reg, rt_rdy_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] survivor_vec;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic             disp_accept;
    logic             issue_accept;
    logic             alloc_en;
    logic             disp_ra_rdy_eff;
    logic             disp_rt_rdy_eff;

    // True when any strobed broadcast port carries this tag.
    function automatic logic tag_hit(input logic [TAG_W-1:0]            tag,
                                     input logic [NUM_WAKEUP-1:0]       v,
                                     input logic [NUM_WAKEUP*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            if (v[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Handshakes. disp_ready looks only at registered occupancy, so a slot
    // freed by this cycle's issue is not reusable until the next cycle.
    assign disp_ready   = (count_reg < CNT_W'(DEPTH));
    assign disp_accept  = disp_valid & disp_ready;
    assign iss_valid    = |ready_vec;
    assign issue_accept = iss_valid & iss_ready;
    assign alloc_en     = disp_accept & ~flush;
    assign survivor_vec = valid_reg & ~(grant & {DEPTH{issue_accept}});

    // A broadcast in the dispatch cycle must not be lost for the incoming op.
    assign disp_ra_rdy_eff = disp_ra_rdy | (disp_use_ra & tag_hit(disp_ra_tag, wk_valid, wk_tag));
    assign disp_rt_rdy_eff = disp_rt_rdy | (disp_use_rt & tag_hit(disp_rt_tag, wk_valid, wk_tag));

    assign disp_entry = '{
        rob:     disp_rob,
        alu_op:  disp_alu_op,
        immdt:   disp_immdt,
        use_ra:  disp_use_ra,
        ra_tag:  disp_ra_tag,
        use_rt:  disp_use_rt,
        rt_tag:  disp_rt_tag,
        use_rw:  disp_use_rw,
        rw_tag:  disp_rw_tag,
        rv_addr: disp_rv_addr,
        rs_addr: disp_rs_addr
    };

    // Lowest-index free slot; a free slot always exists when disp_ready is high.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // Per-entry readiness, wakeup and valid tracking.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic alloc_here;
        logic issue_here;
        logic ra_wake;
        logic rt_wake;

        assign alloc_here = alloc_en && (alloc_idx == IDX_W'(gi));
        assign issue_here = issue_accept && grant[gi];
        assign ra_wake    = valid_reg[gi] && entry_reg[gi].use_ra &&
                            tag_hit(entry_reg[gi].ra_tag, wk_valid, wk_tag);
        assign rt_wake    = valid_reg[gi] && entry_reg[gi].use_rt &&
                            tag_hit(entry_reg[gi].rt_tag, wk_valid, wk_tag);

        assign ready_vec[gi] = valid_reg[gi] &&
                               (!entry_reg[gi].use_ra || ra_rdy_reg[gi]) &&
                               (!entry_reg[gi].use_rt || rt_rdy_reg[gi]);

        assign valid_next[gi]  = !flush && (alloc_here || (valid_reg[gi] && !issue_here));
        assign ra_rdy_next[gi] = alloc_here ? disp_ra_rdy_eff : (ra_rdy_reg[gi] || ra_wake);
        assign rt_rdy_next[gi] = alloc_here ? disp_rt_rdy_eff : (rt_rdy_reg[gi] || rt_wake);
    end

    assign count_next = flush ? '0
                              : (count_reg + CNT_W'(disp_accept) - CNT_W'(issue_accept));

    // Control state: valid/ready bits and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_reg  <= '0;
            ra_rdy_reg <= '0;
            rt_rdy_reg <= '0;
            count_reg  <= '0;
        end else begin
            valid_reg  <= valid_next;
            ra_rdy_reg <= ra_rdy_next;
            rt_rdy_reg <= rt_rdy_next;
            count_reg  <= count_next;
        end
    end

    // Payload storage; written once at allocation and gated by valid_reg.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            entry_reg[alloc_idx] <= disp_entry;
        end
    end

    iq_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .clk       (clk),
        .n_rst     (n_rst),
        .ready     (ready_vec),
        .valid     (survivor_vec),
        .alloc_en  (alloc_en),
        .alloc_idx (alloc_idx),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Issue port fields are forced to zero whenever nothing is presented.
    always_comb begin
        iss_rob     = '0;
        iss_alu_op  = ALU_ADD;
        iss_immdt   = '0;
        iss_ra_tag  = '0;
        iss_use_rt  = 1'b0;
        iss_rt_tag  = '0;
        iss_use_rw  = 1'b0;
        iss_rw_tag  = '0;
        iss_rv_addr = '0;
        iss_rs_addr = '0;
        if (iss_valid) begin
            iss_rob     = entry_reg[grant_idx].rob;
            iss_alu_op  = entry_reg[grant_idx].alu_op;
            iss_immdt   = entry_reg[grant_idx].immdt;
            iss_ra_tag  = entry_reg[grant_idx].ra_tag;
            iss_use_rt  = entry_reg[grant_idx].use_rt;
            iss_rt_tag  = entry_reg[grant_idx].rt_tag;
            iss_use_rw  = entry_reg[grant_idx].use_rw;
            iss_rw_tag  = entry_reg[grant_idx].rw_tag;
            iss_rv_addr = entry_reg[grant_idx].rv_addr;
            iss_rs_addr = entry_reg[grant_idx].rs_addr;
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios followed by random traffic, all
// checked every cycle against an ordered-list model of the queue.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int NW    = 2;
    localparam int TAG_W = 6;
    localparam int ROB_W = 4;
    localparam int RS_W  = 3;

    typedef struct packed {
        logic [3:0]  rob;
        logic [3:0]  alu;
        logic [5:0]  immdt;
        logic        use_ra;
        logic [5:0]  ra_tag;
        logic        ra_rdy;
        logic        use_rt;
        logic [5:0]  rt_tag;
        logic        rt_rdy;
        logic        use_rw;
        logic [5:0]  rw_tag;
        logic [15:0] rv_addr;
        logic [2:0]  rs_addr;
    } op_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    op_t         d;
    logic [1:0]  wk_valid;
    logic [5:0]  wk_t0, wk_t1;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_rob;
    AluOp        iss_alu_op;
    logic [5:0]  iss_immdt;
    logic [5:0]  iss_ra_tag;
    logic        iss_use_rt;
    logic [5:0]  iss_rt_tag;
    logic        iss_use_rw;
    logic [5:0]  iss_rw_tag;
    logic [15:0] iss_rv_addr;
    logic [2:0]  iss_rs_addr;
    logic [3:0]  count;

    op_t mq[$];          // model: valid ops, oldest first
    int  errors = 0;
    int  checks = 0;
    int  seq    = 0;

    always #5 clk = ~clk;

    issue_queue #(
        .DEPTH(DEPTH), .NUM_WAKEUP(NW), .TAG_W(TAG_W), .ROB_W(ROB_W), .RS_W(RS_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_rob(d.rob), .disp_alu_op(AluOp'(d.alu)), .disp_immdt(d.immdt),
        .disp_use_ra(d.use_ra), .disp_use_rt(d.use_rt),
        .disp_ra_tag(d.ra_tag), .disp_rt_tag(d.rt_tag),
        .disp_ra_rdy(d.ra_rdy), .disp_rt_rdy(d.rt_rdy),
        .disp_use_rw(d.use_rw), .disp_rw_tag(d.rw_tag),
        .disp_rv_addr(d.rv_addr), .disp_rs_addr(d.rs_addr),
        .wk_valid(wk_valid), .wk_tag({wk_t1, wk_t0}),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rob(iss_rob), .iss_alu_op(iss_alu_op), .iss_immdt(iss_immdt),
        .iss_ra_tag(iss_ra_tag), .iss_use_rt(iss_use_rt), .iss_rt_tag(iss_rt_tag),
        .iss_use_rw(iss_use_rw), .iss_rw_tag(iss_rw_tag),
        .iss_rv_addr(iss_rv_addr), .iss_rs_addr(iss_rs_addr),
        .count(count)
    );

    function automatic bit op_ready(op_t o);
        return (!o.use_ra || o.ra_rdy) && (!o.use_rt || o.rt_rdy);
    endfunction

    // Position of the oldest ready op in the model, -1 if none.
    function automatic int oldest();
        for (int i = 0; i < mq.size(); i++) begin
            if (op_ready(mq[i])) return i;
        end
        return -1;
    endfunction

    function automatic op_t wake(op_t o);
        op_t r = o;
        for (int k = 0; k < NW; k++) begin
            if (wk_valid[k]) begin
                if (r.use_ra && r.ra_tag == ((k == 0) ? wk_t0 : wk_t1)) r.ra_rdy = 1'b1;
                if (r.use_rt && r.rt_tag == ((k == 0) ? wk_t0 : wk_t1)) r.rt_rdy = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic op_t mk_op(int use_ra, int ra_tag, int ra_rdy,
                                  int use_rt, int rt_tag, int rt_rdy);
        op_t o;
        o.rob     = 4'(seq);
        o.alu     = 4'($urandom_range(0, 15));
        o.immdt   = 6'($urandom);
        o.use_ra  = 1'(use_ra);
        o.ra_tag  = 6'(ra_tag);
        o.ra_rdy  = 1'(ra_rdy);
        o.use_rt  = 1'(use_rt);
        o.rt_tag  = 6'(rt_tag);
        o.rt_rdy  = 1'(rt_rdy);
        o.use_rw  = 1'($urandom_range(0, 1));
        o.rw_tag  = 6'($urandom);
        o.rv_addr = 16'($urandom);
        o.rs_addr = 3'($urandom);
        seq++;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int          r = oldest();
        op_t         o;
        logic [63:0] exp_f = '0;
        logic [63:0] obs_f;
        if (r >= 0) begin
            o = mq[r];
            exp_f = 64'({o.rob, o.alu, o.immdt, o.ra_tag, o.use_rt, o.rt_tag,
                         o.use_rw, o.rw_tag, o.rv_addr, o.rs_addr});
        end
        obs_f = 64'({iss_rob, 4'(iss_alu_op), iss_immdt, iss_ra_tag, iss_use_rt, iss_rt_tag,
                     iss_use_rw, iss_rw_tag, iss_rv_addr, iss_rs_addr});
        chk({tag, ":iss_valid"}, 64'(iss_valid), 64'(r >= 0));
        chk({tag, ":iss_fields"}, obs_f, exp_f);
        chk({tag, ":count"}, 64'(count), 64'(mq.size()));
        chk({tag, ":disp_ready"}, 64'(disp_ready), 64'(mq.size() < DEPTH));
    endtask

    // Advance one clock: update the model from pre-edge state and the driven
    // inputs, then compare the DUT on the following falling edge.
    task automatic cyc(input string tag);
        int  r     = oldest();
        bit  acc_d = disp_valid && (mq.size() < DEPTH);
        bit  acc_i = (r >= 0) && iss_ready;
        op_t iss_op;
        if (acc_i) iss_op = mq[r];
        if (flush) begin
            mq.delete();
        end else begin
            if (acc_i) mq.delete(r);
            foreach (mq[i]) mq[i] = wake(mq[i]);
            if (acc_d) mq.push_back(wake(d));
        end
        if (acc_d || acc_i || flush)
            $display("[%0t] %s disp=%0b rob_in=%0h issue=%0b rob_out=%0h flush=%0b count_next=%0d",
                     $time, tag, acc_d, d.rob, acc_i, acc_i ? iss_op.rob : 4'h0, flush, mq.size());
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        wk_valid   = 2'b00;
        wk_t0      = '0;
        wk_t1      = '0;
        iss_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        idle();
        d = mk_op(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        n_rst = 1'b1;

        // Single ready op: visible next cycle, then issued.
        d = mk_op(1, 1, 1, 0, 0, 0);
        d.rob = 4'd3;
        disp_valid = 1'b1;
        cyc("t1_disp");
        idle();
        iss_ready = 1'b1;
        cyc("t1_issue");

        // A waits on tag 5, younger B issues first, wakeup on port 1 frees A.
        idle();
        d = mk_op(1, 5, 0, 0, 0, 0);
        disp_valid = 1'b1;
        cyc("t2_dispA");
        d = mk_op(1, 2, 1, 0, 0, 0);
        cyc("t2_dispB");
        idle();
        iss_ready = 1'b1;
        cyc("t2_issueB");
        wk_valid = 2'b10;
        wk_t1    = 6'd5;
        cyc("t2_wake");
        wk_valid = 2'b00;
        cyc("t2_issueA");
        cyc("t2_empty");

        // C, D, E ready but stalled; then drained oldest first.
        idle();
        for (int i = 0; i < 3; i++) begin
            d = mk_op(1, i, 1, 1, i + 1, 1);
            disp_valid = 1'b1;
            cyc("t3_disp");
        end
        idle();
        for (int i = 0; i < 3; i++) cyc("t3_hold");
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc("t3_drain");

        // Fill to DEPTH; dispatch during a full-cycle issue is refused once.
        idle();
        disp_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            d = mk_op(0, 0, 0, 0, 0, 0);
            cyc("t4_fill");
        end
        d = mk_op(0, 0, 0, 0, 0, 0);
        iss_ready = 1'b1;
        cyc("t4_full_issue");
        iss_ready = 1'b0;
        cyc("t4_retry");
        idle();
        iss_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cyc("t4_drain");

        // Wakeup coincident with dispatch.
        idle();
        d = mk_op(0, 0, 0, 1, 9, 0);
        disp_valid = 1'b1;
        wk_valid   = 2'b01;
        wk_t0      = 6'd9;
        cyc("t5_disp_wake");
        idle();
        iss_ready = 1'b1;
        cyc("t5_issue");

        // Flush with a dispatch in the same cycle.
        idle();
        disp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = mk_op(1, 20 + i, 0, 0, 0, 0);
            cyc("t6_fill");
        end
        d = mk_op(0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        cyc("t6_flush");
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = mk_op(0, 0, 0, 0, 0, 0);
            cyc("t6_refill");
        end

        // Asynchronous reset between clock edges clears state immediately.
        idle();
        #2;
        n_rst = 1'b0;
        #1;
        chk("t6_async:count", 64'(count), 64'd0);
        chk("t6_async:iss_valid", 64'(iss_valid), 64'd0);
        chk("t6_async:disp_ready", 64'(disp_ready), 64'd1);
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        check_all("t6_after_reset");

        // Random traffic with small tag space so wakeups frequently hit.
        for (int n = 0; n < 600; n++) begin
            disp_valid = ($urandom_range(0, 99) < 60);
            d = mk_op($urandom_range(0, 1), $urandom_range(0, 7), ($urandom_range(0, 99) < 30),
                      $urandom_range(0, 1), $urandom_range(0, 7), ($urandom_range(0, 99) < 30));
            wk_valid  = 2'($urandom_range(0, 3));
            wk_t0     = 6'($urandom_range(0, 7));
            wk_t1     = 6'($urandom_range(0, 7));
            iss_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 99) < 2);
            cyc("rand");
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
